// File: rtl/ps2_message_assembler_pkg.sv
// ---------------------------------------------------------------------------
// ps2_message_assembler_pkg
//   Shared definitions for the PS/2 message assembler:
//     - PS/2 set-2 control bytes and special ASCII values
//     - scan-decoder state encoding (make / break / extended prefixes)
//     - message-buffer state encoding (filling vs. holding for downstream)
// ---------------------------------------------------------------------------
package ps2_message_assembler_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_ENTER = 8'h5A;
    localparam logic [7:0] PS2_BKSP  = 8'h66;
    localparam logic [7:0] PS2_SPACE = 8'h29;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [1:0] {
        DEC_NORMAL    = 2'd0,
        DEC_BREAK     = 2'd1,
        DEC_EXT       = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_e;

    typedef enum logic {
        BUF_FILL = 1'b0,
        BUF_HOLD = 1'b1
    } buf_state_e;

endpackage

// File: rtl/ps2_message_assembler_scan_to_ascii.sv
// ---------------------------------------------------------------------------
// ps2_message_assembler_scan_to_ascii
//   Combinational lookup from a PS/2 set-2 make code to lower-case ASCII.
//   Only a-z, 0-9 and space are printable; everything else reports
//   printable=0 with ascii=8'h00.
// Ports
//   scan_code  in   8  PS/2 set-2 make code
//   printable  out  1  code maps to a storable character
//   ascii      out  8  ASCII value when printable, else 8'h00
// ---------------------------------------------------------------------------
module ps2_message_assembler_scan_to_ascii
    import ps2_message_assembler_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       printable,
    output logic [7:0] ascii
);

    always_comb begin
        printable = 1'b1;
        ascii     = 8'h00;
        case (scan_code)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62; // b
            8'h21: ascii = 8'h63; // c
            8'h23: ascii = 8'h64; // d
            8'h24: ascii = 8'h65; // e
            8'h2B: ascii = 8'h66; // f
            8'h34: ascii = 8'h67; // g
            8'h33: ascii = 8'h68; // h
            8'h43: ascii = 8'h69; // i
            8'h3B: ascii = 8'h6A; // j
            8'h42: ascii = 8'h6B; // k
            8'h4B: ascii = 8'h6C; // l
            8'h3A: ascii = 8'h6D; // m
            8'h31: ascii = 8'h6E; // n
            8'h44: ascii = 8'h6F; // o
            8'h4D: ascii = 8'h70; // p
            8'h15: ascii = 8'h71; // q
            8'h2D: ascii = 8'h72; // r
            8'h1B: ascii = 8'h73; // s
            8'h2C: ascii = 8'h74; // t
            8'h3C: ascii = 8'h75; // u
            8'h2A: ascii = 8'h76; // v
            8'h1D: ascii = 8'h77; // w
            8'h22: ascii = 8'h78; // x
            8'h35: ascii = 8'h79; // y
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            PS2_SPACE: ascii = 8'h20;
            default: printable = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_message_assembler.sv
// ---------------------------------------------------------------------------
// ps2_message_assembler
//   Turns a stream of PS/2 set-2 scan bytes into a fixed-length ASCII
//   message. Make codes of printable keys are appended, backspace deletes
//   the last character, Enter commits the message and holds it under a
//   valid/ack handshake. Each accepted character or delete also produces a
//   one-cycle ASCII strobe for a display.
// Ports
//   clock       in   1    system clock, all logic on posedge
//   resetn      in   1    asynchronous active-low reset
//   scan_valid  in   1    one-cycle strobe, scan_code valid
//   scan_code   in   8    PS/2 set-2 scan byte
//   msg_ack     in   1    downstream accepted the held message
//   msg_valid   out  1    committed message held on msg_data
//   msg_data    out  MSG_CHARS*CHAR_W  char 0 in the MSBs, empty slots 0
//   char_count  out  clog2(MSG_CHARS+1)  characters buffered
//   char_valid  out  1    strobe per accepted char or delete
//   char_ascii  out  8    ASCII of last strobe (8'h7F = delete)
// ---------------------------------------------------------------------------
module ps2_message_assembler
    import ps2_message_assembler_pkg::*;
#(
    parameter int MSG_CHARS = 16,
    parameter int CHAR_W    = 8
)
(
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              scan_valid,
    input  logic [7:0]                        scan_code,
    input  logic                              msg_ack,
    output logic                              msg_valid,
    output logic [MSG_CHARS*CHAR_W-1:0]       msg_data,
    output logic [$clog2(MSG_CHARS+1)-1:0]    char_count,
    output logic                              char_valid,
    output logic [7:0]                        char_ascii
);

    localparam int CNT_W = $clog2(MSG_CHARS + 1);
    localparam int IDX_W = $clog2(MSG_CHARS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MSG_CHARS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dec_state_e         dec_state_q, dec_state_d;
    buf_state_e         buf_state_q, buf_state_d;
    logic [CHAR_W-1:0]  slots_q [MSG_CHARS];
    logic [CHAR_W-1:0]  slots_d [MSG_CHARS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               char_valid_q, char_valid_d;
    logic [7:0]         char_ascii_q, char_ascii_d;

    logic               make_evt;
    logic               printable;
    logic [7:0]         key_ascii;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   del_idx;

    ps2_message_assembler_scan_to_ascii u_scan_to_ascii (
        .scan_code (scan_code),
        .printable (printable),
        .ascii     (key_ascii)
    );

    // When count==MSG_CHARS the low bits wrap to 0, so del_idx still lands
    // on the last slot; wr_idx is only used while count<MSG_CHARS.
    assign wr_idx  = count_q[IDX_W-1:0];
    assign del_idx = count_q[IDX_W-1:0] - IDX_W'(1);

    // Scan decoder: only a plain byte seen in NORMAL is a key press.
    always_comb begin
        dec_state_d = dec_state_q;
        make_evt    = 1'b0;
        if (scan_valid) begin
            case (dec_state_q)
                DEC_NORMAL: begin
                    if (scan_code == PS2_BREAK)    dec_state_d = DEC_BREAK;
                    else if (scan_code == PS2_EXT) dec_state_d = DEC_EXT;
                    else                           make_evt    = 1'b1;
                end
                DEC_BREAK:     dec_state_d = DEC_NORMAL;
                DEC_EXT: begin
                    if (scan_code == PS2_BREAK) dec_state_d = DEC_EXT_BREAK;
                    else                        dec_state_d = DEC_NORMAL;
                end
                DEC_EXT_BREAK: dec_state_d = DEC_NORMAL;
                default:       dec_state_d = DEC_NORMAL;
            endcase
        end
    end

    // Message buffer: edits in FILL, frozen in HOLD until acknowledged.
    always_comb begin
        buf_state_d  = buf_state_q;
        slots_d      = slots_q;
        count_d      = count_q;
        char_valid_d = 1'b0;
        char_ascii_d = char_ascii_q;
        case (buf_state_q)
            BUF_HOLD: begin
                // Any key arriving with the ack is dropped.
                if (msg_ack) begin
                    buf_state_d = BUF_FILL;
                    count_d     = '0;
                    for (int i = 0; i < MSG_CHARS; i++) begin
                        slots_d[i] = '0;
                    end
                end
            end
            default: begin
                if (make_evt) begin
                    if (printable) begin
                        if (count_q < CNT_MAX) begin
                            slots_d[wr_idx] = CHAR_W'(key_ascii);
                            count_d         = count_q + CNT_ONE;
                            char_valid_d    = 1'b1;
                            char_ascii_d    = key_ascii;
                        end
                    end else if (scan_code == PS2_BKSP) begin
                        if (count_q != '0) begin
                            slots_d[del_idx] = '0;
                            count_d          = count_q - CNT_ONE;
                            char_valid_d     = 1'b1;
                            char_ascii_d     = ASCII_DEL;
                        end
                    end else if (scan_code == PS2_ENTER) begin
                        if (count_q != '0) buf_state_d = BUF_HOLD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dec_state_q  <= DEC_NORMAL;
            buf_state_q  <= BUF_FILL;
            count_q      <= '0;
            char_valid_q <= 1'b0;
            char_ascii_q <= 8'h00;
            for (int i = 0; i < MSG_CHARS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            dec_state_q  <= dec_state_d;
            buf_state_q  <= buf_state_d;
            count_q      <= count_d;
            char_valid_q <= char_valid_d;
            char_ascii_q <= char_ascii_d;
            slots_q      <= slots_d;
        end
    end

    always_comb begin
        msg_data = '0;
        for (int i = 0; i < MSG_CHARS; i++) begin
            msg_data[(MSG_CHARS-1-i)*CHAR_W +: CHAR_W] = slots_q[i];
        end
    end

    assign msg_valid  = (buf_state_q == BUF_HOLD);
    assign char_count = count_q;
    assign char_valid = char_valid_q;
    assign char_ascii = char_ascii_q;

endmodule
